seq_mac32: RTL and testbench



---
 rtl/seq_mac_pkg.sv | 21 ++
 rtl/fa32bit_sc.sv | 23 ++
 rtl/seq_mac32.sv | 154 +++++++++++++++
 tb/tb_seq_mac32.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mac_pkg.sv
// Shared encodings and constants for the seq_mac32 multiply-accumulate unit.
package seq_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_MAC = 2'b00,
    OP_MUL = 2'b01,
    OP_CLR = 2'b10,
    OP_NOP = 2'b11
  } op_e;

  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;

endpackage

// File: rtl/fa32bit_sc.sv
// 32-bit ripple-carry adder used for the accumulate step.
module fa32bit_sc (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] SUM,
  output logic        Cout
);

  logic carry;

  // Bit-serial carry chain, LSB to MSB.
  always_comb begin
    carry = Cin;
    SUM   = '0;
    for (int i = 0; i < 32; i++) begin
      SUM[i] = A[i] ^ B[i] ^ carry;
      carry  = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
    end
    Cout = carry;
  end

endmodule

// File: rtl/seq_mac32.sv
// Multi-cycle signed OPWxOPW multiply-accumulate with start/ready/done handshake.
// Product is built by LSB-first shift-add on operand magnitudes, then the
// signed product is added to the accumulator through fa32bit_sc.
module seq_mac32
  import seq_mac_pkg::*;
#(
  parameter int OPW  = 16,
  parameter int ACCW = 32,
  parameter int SAT  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  output logic            ready,
  output logic            done,
  output logic [ACCW-1:0] acc,
  output logic            ovf
);

  localparam int CW = $clog2(OPW);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OPW-1:0]  ma_q, ma_d;
  logic [OPW-1:0]  mb_q, mb_d;
  logic [ACCW-1:0] p_q, p_d;
  logic            sign_q, sign_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;

  logic [ACCW-1:0] add_a, add_b, add_sum, pp;
  logic            add_ovf;
  logic            unused_cout;

  // -32768 maps to 0x8000, which is the correct unsigned magnitude.
  function automatic logic [OPW-1:0] mag(input logic [OPW-1:0] v);
    return v[OPW-1] ? (~v + OPW'(1)) : v;
  endfunction

  fa32bit_sc u_add (
    .A    (add_a),
    .B    (add_b),
    .Cin  (1'b0),
    .SUM  (add_sum),
    .Cout (unused_cout)
  );

  // Adder operands and signed overflow detect for the accumulate step.
  always_comb begin
    add_a   = (op_q == OP_MUL) ? '0 : acc_q;
    add_b   = sign_q ? ('0 - p_q) : p_q;
    add_ovf = (add_a[ACCW-1] == add_b[ACCW-1]) && (add_sum[ACCW-1] != add_a[ACCW-1]);
    pp      = mb_q[cnt_q] ? ({{(ACCW-OPW){1'b0}}, ma_q} << cnt_q) : '0;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    p_d     = p_q;
    sign_d  = sign_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op_e'(op))
            OP_MAC, OP_MUL: begin
              ma_d    = mag(a);
              mb_d    = mag(b);
              sign_d  = a[OPW-1] ^ b[OPW-1];
              op_d    = op_e'(op);
              p_d     = '0;
              cnt_d   = '0;
              state_d = ST_MUL;
            end
            OP_CLR: begin
              acc_d   = '0;
              ovf_d   = 1'b0;
              op_d    = OP_CLR;
              state_d = ST_DONE;
            end
            default: begin
              op_d    = OP_NOP;
              state_d = ST_DONE;
            end
          endcase
        end
      end
      ST_MUL: begin
        p_d   = p_q + pp;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(OPW - 1)) state_d = ST_ACC;
      end
      ST_ACC: begin
        if (add_ovf) begin
          ovf_d = 1'b1;
          if (SAT != 0) acc_d = add_a[ACCW-1] ? SAT_NEG : SAT_POS;
          else          acc_d = add_sum;
        end else begin
          acc_d = add_sum;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      p_q     <= '0;
      sign_q  <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      p_q     <= p_d;
      sign_q  <= sign_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign done  = done_q;
  assign acc   = acc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_seq_mac32.sv
// Scoreboard bench for seq_mac32: one instance saturating, one wrapping,
// driven by the same stimulus. Expectations are queued at accept and
// checked by a monitor on every done pulse.
module tb_seq_mac32;

  localparam logic [1:0] MAC = 2'b00;
  localparam logic [1:0] MUL = 2'b01;
  localparam logic [1:0] CLR = 2'b10;
  localparam logic [1:0] NOP = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] a = '0, b = '0;
  logic        ready1, done1, ovf1, ready0, done0, ovf0;
  logic [31:0] acc1, acc0;

  seq_mac32 #(.OPW(16), .ACCW(32), .SAT(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .ready(ready1), .done(done1), .acc(acc1), .ovf(ovf1));

  seq_mac32 #(.OPW(16), .ACCW(32), .SAT(0)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .ready(ready0), .done(done0), .acc(acc0), .ovf(ovf0));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] acc1;
    logic        ovf1;
    logic [31:0] acc0;
    logic        ovf0;
    int          k;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0, passed = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;

  // model state (random phase only)
  logic [31:0] m_acc1 = '0, m_acc0 = '0;
  logic        m_ovf1 = 1'b0, m_ovf0 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pop and compare on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done1 || done0) begin
        done_cnt++;
        chk("done_width", {31'b0, prev_done}, 32'd0);
        chk("done_s1", {31'b0, done1}, 32'd1);
        chk("done_s0", {31'b0, done0}, 32'd1);
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got done with empty scoreboard (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("acc_sat", acc1, e.acc1);
          chk("ovf_sat", {31'b0, ovf1}, {31'b0, e.ovf1});
          chk("acc_wrap", acc0, e.acc0);
          chk("ovf_wrap", {31'b0, ovf0}, {31'b0, e.ovf0});
          chk("latency", cyc - e.k, e.lat);
        end
      end
      prev_done = done1;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ready1 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ready1 !== 1'b1) begin
      checks++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", ready1, n);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d expectations pending, required 0", q.size());
    end
  endtask

  // Issue one op at a negedge; expectation pushed right after the accept edge.
  task automatic issue(input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv,
                       input logic [31:0] ea1, input logic eo1,
                       input logic [31:0] ea0, input logic eo0);
    exp_t e;
    wait_ready();
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    #1;
    e.acc1 = ea1; e.ovf1 = eo1; e.acc0 = ea0; e.ovf0 = eo0;
    e.k = cyc;
    e.lat = (o == CLR || o == NOP) ? 1 : 18;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic model(input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv,
                       input bit sat, inout logic [31:0] macc, inout logic movf);
    longint p, base, s;
    if (o == CLR) begin
      macc = '0; movf = 1'b0;
    end else if (o != NOP) begin
      p    = longint'($signed(av)) * longint'($signed(bv));
      base = (o == MUL) ? 64'sd0 : longint'($signed(macc));
      s    = base + p;
      if (s > 64'sd2147483647 || s < -64'sd2147483648) begin
        movf = 1'b1;
        macc = sat ? ((s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000) : s[31:0];
      end else begin
        macc = s[31:0];
      end
    end
  endtask

  initial begin
    int d0;
    logic [1:0]  ro;
    logic [15:0] ra, rb;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_acc_s1", acc1, 32'h0);
    chk("rst_acc_s0", acc0, 32'h0);
    chk("rst_ovf", {30'b0, ovf1, ovf0}, 32'h0);
    chk("rst_ready", {30'b0, ready1, ready0}, 32'h3);
    chk("rst_done", {30'b0, done1, done0}, 32'h0);

    issue(MAC, 16'hFFF6, 16'd8, 32'hFFFF_FFB0, 0, 32'hFFFF_FFB0, 0);
    issue(MAC, 16'd3,    16'd7, 32'hFFFF_FFC5, 0, 32'hFFFF_FFC5, 0);
    issue(MUL, 16'h8000, 16'd1, 32'hFFFF_8000, 0, 32'hFFFF_8000, 0);
    issue(MUL, 16'h8000, 16'h8000, 32'h4000_0000, 0, 32'h4000_0000, 0);
    issue(MAC, 16'h8000, 16'h8000, 32'h7FFF_FFFF, 1, 32'h8000_0000, 1);
    issue(MAC, 16'd1,    16'd1, 32'h7FFF_FFFF, 1, 32'h8000_0001, 1);
    issue(MUL, 16'd2,    16'd3, 32'h0000_0006, 1, 32'h0000_0006, 1);
    issue(NOP, 16'd9,    16'd9, 32'h0000_0006, 1, 32'h0000_0006, 1);
    issue(CLR, 16'd0,    16'd0, 32'h0, 0, 32'h0, 0);

    // negative boundary: exactly -2^31 fits, one more overflows
    issue(MUL, 16'h8000, 16'h7FFF, 32'hC000_8000, 0, 32'hC000_8000, 0);
    issue(MAC, 16'h8000, 16'h7FFF, 32'h8001_0000, 0, 32'h8001_0000, 0);
    issue(MAC, 16'h8000, 16'd2,    32'h8000_0000, 0, 32'h8000_0000, 0);
    issue(MAC, 16'hFFFF, 16'd1,    32'h8000_0000, 1, 32'h7FFF_FFFF, 1);
    issue(CLR, 16'd0,    16'd0,    32'h0, 0, 32'h0, 0);

    // start while busy is ignored
    issue(MAC, 16'd5, 16'hFFFD, 32'hFFFF_FFF1, 0, 32'hFFFF_FFF1, 0);
    d0 = done_cnt;
    repeat (4) @(negedge clk);
    chk("busy_ready", {30'b0, ready1, ready0}, 32'h0);
    start = 1'b1; op = MAC; a = 16'd100; b = 16'd100;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    wait_ready();
    repeat (3) @(negedge clk);
    chk("one_done_busy", done_cnt - d0, 32'd1);

    // reset during MUL aborts without a done pulse
    issue(CLR, 16'd0, 16'd0, 32'h0, 0, 32'h0, 0);
    issue(MAC, 16'd10, 16'd8, 32'h0000_0050, 0, 32'h0000_0050, 0);
    issue(MAC, 16'd1, 16'd1, 32'h0000_0051, 0, 32'h0000_0051, 0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    chk("abort_acc", acc1 | acc0, 32'h0);
    chk("abort_ready", {30'b0, ready1, ready0}, 32'h3);
    chk("abort_ovf", {30'b0, ovf1, ovf0}, 32'h0);
    repeat (25) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 32'd0);
    issue(MAC, 16'd2, 16'd2, 32'h4, 0, 32'h4, 0);

    // random sweep against the behavioural model, from a cleared accumulator
    issue(CLR, 16'd0, 16'd0, 32'h0, 0, 32'h0, 0);
    m_acc1 = '0; m_acc0 = '0; m_ovf1 = 1'b0; m_ovf0 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      int r;
      r  = $urandom_range(0, 9);
      ro = (r < 5) ? MAC : (r < 8) ? MUL : (r < 9) ? CLR : NOP;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 16'h8000;
      if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
      model(ro, ra, rb, 1'b1, m_acc1, m_ovf1);
      model(ro, ra, rb, 1'b0, m_acc0, m_ovf0);
      issue(ro, ra, rb, m_acc1, m_ovf1, m_acc0, m_ovf0);
    end

    wait_drain();
    wait_ready();
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
